// File: rtl/line_clear_engine.sv
// Post-lock line clear: scans the map bottom-up, drops full rows, compacts
// the survivors downward, zero-fills the top and reports lines/score.
module line_clear_engine #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 5
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic [4:0]             rd_row,
    input  logic [COLS*CELL_W-1:0] rd_data,
    output logic                   wr_en,
    output logic [4:0]             wr_row,
    output logic [COLS*CELL_W-1:0] wr_data,
    output logic                   done,
    output logic [4:0]             lines_cleared,
    output logic [10:0]            score_add
);

    localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);
    localparam logic [CELL_W-1:0] MAX_LOCKED = CELL_W'(9);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_FILL, S_DONE} state_t;

    state_t                  r_state;
    logic [4:0]              r_src;
    logic [4:0]              r_dst;
    logic [4:0]              r_cnt;
    logic                    r_busy;
    logic [4:0]              r_rd_row;
    logic                    r_wr_en;
    logic [4:0]              r_wr_row;
    logic [COLS*CELL_W-1:0]  r_wr_data;
    logic                    r_done;
    logic [4:0]              r_lines;
    logic [10:0]             r_score;

    logic                    w_row_full;
    logic [CELL_W-1:0]       w_cell;
    logic [10:0]             w_score;

    // A row is full only if every cell holds a locked code (1..9).
    always_comb begin
        w_row_full = 1'b1;
        w_cell     = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            w_cell = rd_data[c*CELL_W +: CELL_W];
            if ((w_cell == '0) || (w_cell > MAX_LOCKED)) begin
                w_row_full = 1'b0;
            end
        end
    end

    always_comb begin
        case (r_cnt)
            5'd0:    w_score = 11'd0;
            5'd1:    w_score = 11'd40;
            5'd2:    w_score = 11'd100;
            5'd3:    w_score = 11'd300;
            default: w_score = 11'd1200;
        endcase
    end

    // rd_row is loaded on entry to READ so a one-cycle-latency map read
    // presents the row during EVAL.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src     <= LAST_ROW;
            r_dst     <= LAST_ROW;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_rd_row  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_lines   <= '0;
            r_score   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_src    <= LAST_ROW;
                        r_dst    <= LAST_ROW;
                        r_rd_row <= LAST_ROW;
                        r_busy   <= 1'b1;
                        r_state  <= S_READ;
                    end
                end
                S_READ: begin
                    r_rd_row <= r_src;
                    r_state  <= S_EVAL;
                end
                S_EVAL: begin
                    if (w_row_full) begin
                        r_cnt <= r_cnt + 5'd1;
                    end else begin
                        if (r_dst != r_src) begin
                            r_wr_en   <= 1'b1;
                            r_wr_row  <= r_dst;
                            r_wr_data <= rd_data;
                        end
                        r_dst <= r_dst - 5'd1;
                    end
                    if (r_src == '0) begin
                        r_state <= (w_row_full || (r_cnt != '0)) ? S_FILL : S_DONE;
                    end else begin
                        r_src    <= r_src - 5'd1;
                        r_rd_row <= r_src - 5'd1;
                        r_state  <= S_READ;
                    end
                end
                S_FILL: begin
                    // dst ends the scan at cnt-1, so filling down to row 0 writes exactly cnt rows.
                    r_wr_en   <= 1'b1;
                    r_wr_row  <= r_dst;
                    r_wr_data <= '0;
                    r_dst     <= r_dst - 5'd1;
                    if (r_dst == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_lines <= r_cnt;
                    r_score <= w_score;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign rd_row        = r_rd_row;
    assign wr_en         = r_wr_en;
    assign wr_row        = r_wr_row;
    assign wr_data       = r_wr_data;
    assign done          = r_done;
    assign lines_cleared = r_lines;
    assign score_add     = r_score;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine with a one-cycle-latency map model.
module tb_line_clear_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic [4:0]  rd_row;
    logic [49:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [49:0] wr_data;
    logic        done;
    logic [4:0]  lines_cleared;
    logic [10:0] score_add;

    logic [49:0] mem      [20];
    logic [49:0] init_mem [20];
    logic [49:0] exp_mem  [20];
    logic        load_req;

    int          n_cmp;
    int          n_fail;

    int          r_lat;
    int          r_nwr;
    int          r_ndone;
    logic        r_busy0;
    logic [4:0]  r_first_row;
    logic [49:0] r_first_data;

    line_clear_engine #(.ROWS(20), .COLS(10), .CELL_W(5)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score_add     (score_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= (rd_row < 5'd20) ? mem[rd_row] : '0;
        if (load_req) begin
            for (int r = 0; r < 20; r++) mem[r] <= init_mem[r];
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    function automatic logic [49:0] full_row(input int seed);
        logic [49:0] v;
        v = '0;
        for (int c = 0; c < 10; c++) v[c*5 +: 5] = 5'((seed + c) % 9 + 1);
        return v;
    endfunction

    task automatic clear_maps();
        for (int r = 0; r < 20; r++) begin
            init_mem[r] = '0;
            exp_mem[r]  = '0;
        end
    endtask

    task automatic load_map();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Pulses start, then observes 100 cycles; optional extra start at cycle extra_at.
    task automatic run(input int extra_at);
        r_lat = -1; r_nwr = 0; r_ndone = 0;
        r_first_row = '0; r_first_data = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_busy0 = busy;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            start = (n == extra_at);
            if (wr_en) begin
                if (r_nwr == 0) begin
                    r_first_row  = wr_row;
                    r_first_data = wr_data;
                end
                r_nwr++;
            end
            if (done) begin
                if (r_ndone == 0) r_lat = n;
                r_ndone++;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_map(input string tag);
        for (int r = 0; r < 20; r++) begin
            n_cmp++;
            if (mem[r] !== exp_mem[r]) begin
                n_fail++;
                $display("FAIL %s row%0d: got %h expected %h", tag, r, mem[r], exp_mem[r]);
            end
        end
    endtask

    task automatic check_result(input string tag, input int lines, input int score, input int nwr);
        // r_lat counts edges after the sampling edge: 41+cnt, i.e. 42+cnt cycles from the start cycle.
        n_cmp++;
        if (r_lat !== 41 + lines) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, r_lat, 41 + lines); end
        n_cmp++;
        if (r_ndone !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, r_ndone); end
        n_cmp++;
        if (lines_cleared !== 5'(lines)) begin n_fail++; $display("FAIL %s lines: got %0d expected %0d", tag, lines_cleared, lines); end
        n_cmp++;
        if (score_add !== 11'(score)) begin n_fail++; $display("FAIL %s score: got %0d expected %0d", tag, score_add, score); end
        n_cmp++;
        if (r_nwr !== nwr) begin n_fail++; $display("FAIL %s writes: got %0d expected %0d", tag, r_nwr, nwr); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, wr_en} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, wr_en}); end
        n_cmp++;
        if ({rd_row, wr_row} !== 10'd0) begin n_fail++; $display("FAIL reset_rows: got %0d/%0d expected 0/0", rd_row, wr_row); end
        n_cmp++;
        if (wr_data !== 50'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        n_cmp++;
        if ({lines_cleared, score_add} !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", lines_cleared, score_add); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_empty();
        clear_maps();
        load_map();
        run(0);
        n_cmp++;
        if (r_busy0 !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b expected 1", r_busy0); end
        check_result("empty", 0, 0, 0);
        check_map("empty");
    endtask

    task automatic test_single_clear();
        clear_maps();
        init_mem[19] = full_row(0);
        init_mem[18] = 50'd3;
        exp_mem[19]  = 50'd3;
        load_map();
        run(0);
        check_result("single", 1, 40, 20);
        n_cmp++;
        if ({r_first_row, r_first_data} !== {5'd19, 50'd3}) begin
            n_fail++; $display("FAIL single_first_write: got row %0d data %h expected row 19 data 3", r_first_row, r_first_data);
        end
        check_map("single");
    endtask

    task automatic test_four_clear();
        logic [49:0] alt;
        alt = '0;
        for (int c = 0; c < 10; c += 2) alt[c*5 +: 5] = 5'd2;
        clear_maps();
        for (int r = 16; r < 20; r++) init_mem[r] = full_row(r);
        init_mem[15] = alt;
        init_mem[0]  = {5'd5, 45'd0};
        exp_mem[19]  = alt;
        exp_mem[4]   = {5'd5, 45'd0};
        load_map();
        run(0);
        check_result("four", 4, 1200, 20);
        check_map("four");
    endtask

    task automatic test_split_clear();
        clear_maps();
        init_mem[19] = full_row(3);
        init_mem[18] = {45'd0, 5'd7};
        init_mem[17] = full_row(5);
        init_mem[16] = {5'd12, 45'd0};
        exp_mem[19]  = {45'd0, 5'd7};
        exp_mem[18]  = {5'd12, 45'd0};
        load_map();
        run(0);
        check_result("split", 2, 100, 20);
        check_map("split");
    endtask

    task automatic test_score_table();
        int ks [2] = '{3, 6};
        int sc [2] = '{300, 1200};
        for (int i = 0; i < 2; i++) begin
            clear_maps();
            for (int r = 20 - ks[i]; r < 20; r++) init_mem[r] = full_row(r + i);
            load_map();
            run(0);
            check_result($sformatf("stack%0d", ks[i]), ks[i], sc[i], 20);
            check_map($sformatf("stack%0d", ks[i]));
        end
    endtask

    task automatic test_not_full();
        logic [49:0] row;
        row = full_row(0);
        for (int c = 0; c < 10; c++) row[c*5 +: 5] = 5'd1;
        row[20 +: 5] = 5'd11;
        clear_maps();
        init_mem[19] = row;
        exp_mem[19]  = row;
        load_map();
        run(0);
        check_result("active_cell", 0, 0, 0);
        check_map("active_cell");
    endtask

    task automatic test_back_to_back();
        clear_maps();
        init_mem[19] = full_row(2);
        init_mem[18] = 50'd3;
        exp_mem[19]  = 50'd3;
        load_map();
        run(10);
        check_result("b2b", 1, 40, 20);
        check_map("b2b");
    endtask

    task automatic test_reset_mid_run();
        int nd;
        int nw;
        clear_maps();
        init_mem[19] = full_row(4);
        init_mem[18] = 50'd3;
        load_map();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, wr_en, done} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b expected 000", {busy, wr_en, done}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        nd = 0; nw = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
            if (wr_en) nw++;
        end
        n_cmp++;
        if (nd !== 0) begin n_fail++; $display("FAIL midreset_done: got %0d expected 0", nd); end
        n_cmp++;
        if (nw !== 0) begin n_fail++; $display("FAIL midreset_writes: got %0d expected 0", nw); end
        n_cmp++;
        if (mem[19] !== full_row(4)) begin n_fail++; $display("FAIL midreset_row19: got %h expected %h", mem[19], full_row(4)); end
        exp_mem[19] = 50'd3;
        run(0);
        check_result("after_reset", 1, 40, 20);
        check_map("after_reset");
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        start = 1'b0;
        reset = 1'b1;
        load_req = 1'b0;
        test_reset();
        test_empty();
        test_single_clear();
        test_four_clear();
        test_split_clear();
        test_score_table();
        test_not_full();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
